dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares one port of a dual-port block RAM (dpram, 1-cycle registered-address read) between two requesters.
- Round-robin arbitration with a req/ack handshake; read data is returned on per-requester rvalid strobes.
- Includes a fill engine that sweeps every word with a constant value after reset or on command, e.g. to clear palette/work RAM before loading.
- Sits between the requesting logic (e.g. loader and sprite/fix fetch) and the address_b/data_b/wren_b/q_b pins of a dpram instance.

Parameters:
- DATAWIDTH, 8: RAM word width.
- ADDRWIDTH, 8: RAM address width.
- NUMWORDS, 1<<ADDRWIDTH: number of words swept by the fill engine; may be a non-power-of-two value.
- CLEAR_ON_RESET, 0: when 1, a fill with value 0 starts automatically on the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle pulse that starts a fill sweep.
- clear_value  in  DATAWIDTH  fill data; sampled on the clear_start cycle.
- clear_busy  out  1  high while a sweep is in progress.
- req0, req1  in  1  access request; must be held until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; held with req.
- addr0, addr1  in  ADDRWIDTH  access address; held with req.
- din0, din1  in  DATAWIDTH  write data; held with req.
- ack0, ack1  out  1  one-cycle pulse: the access has been issued to the RAM.
- rvalid0, rvalid1  out  1  one-cycle pulse: rdataN holds read data.
- rdata0, rdata1  out  DATAWIDTH  read data; held until the next rvalid for that requester.
- ram_addr  out  ADDRWIDTH  to dpram address port.
- ram_data  out  DATAWIDTH  to dpram data port.
- ram_wren  out  1  to dpram write enable.
- ram_q  in  DATAWIDTH  from dpram q port.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, the fill counter is 0, and last_grant = 1, so requester 0 wins the first contest.
- Reset mid-sweep aborts the sweep. It also discards any in-flight reads: no rvalid is issued for them.
- States:
  - IDLE: arbitrate requests.
  - CLEAR: sweep the RAM with the fill value.
- IDLE → CLEAR when clear_start = 1, or on the first post-reset cycle if CLEAR_ON_RESET = 1.
  - clear_start takes precedence over any pending req in the same cycle; no ack is issued that cycle.
- CLEAR operation:
  - Each cycle drives ram_addr = cnt, ram_data = fill value, ram_wren = 1, for cnt = 0 .. NUMWORDS-1, one word per cycle.
  - After issuing word NUMWORDS-1, returns to IDLE and clears the counter to 0.
  - clear_busy is high for exactly NUMWORDS cycles.
  - clear_start is ignored while in CLEAR.
  - req is never acked during CLEAR; requesters simply keep waiting.
  - Reads issued before CLEAR entry still complete normally.
- IDLE arbitration, evaluated each cycle:
  - Only one requester asserted: grant it.
  - Both asserted: grant the one that is not last_grant.
  - On a grant: register ram_addr/ram_data/ram_wren from that requester, pulse ackN, and set last_grant = N.
  - When no req is asserted, ram_wren = 0; ram_addr/ram_data are don't-care.
- Back-to-back throughput:
  - A requester holding req through its ack cycle is presented with a new access. It may be re-granted on the very next cycle if the other requester is idle.
  - Under contention, grants alternate 0,1,0,1.
- Read latency:
  - The access is issued in cycle T (ackN high in T).
  - The RAM samples the address at the end of T; ram_q is valid in T+1.
  - ram_q is captured into rdataN at the end of T+1; rvalidN is high in T+2.
  - The pipeline tags each issued read with its requester ID, so reads are returned in issue order, one per cycle.
- Writes produce no rvalid.
- A read issued the cycle after a write to the same address returns the new data (RAM new-data mode, single port).
- Width rule: the fill counter is ADDRWIDTH+1 bits internally. Its terminal compare is against NUMWORDS-1, not against wrap-around.

Test Plan:
- Reset, CLEAR_ON_RESET=1, NUMWORDS=256 → clear_busy high for exactly 256 cycles with ram_wren=1 and ram_addr 0..255; then both requesters read addr 0x7F → data 0x00.
- Requester 0 writes 0x5A to 0x10, then reads 0x10 → ack0 on each access; rvalid0 exactly 2 cycles after the read ack; rdata0 = 0x5A; rvalid1 stays 0.
- Both requesters hold reads (addr 0x01 / 0x02, preloaded 0xA1 / 0xA2) for 4 cycles → acks alternate 0,1,0,1 starting with requester 0; rdata sequence A1, A2, A1, A2, each returned to the correct requester.
- clear_start with clear_value 0xFF while req1 is pending → no ack1 during the 256-cycle sweep; ack1 on the first IDLE cycle; a subsequent read of any address returns 0xFF.
- Read issued, then reset asserted one cycle later → no rvalid after reset; all outputs 0; next contest is won by requester 0.
- clear_start pulsed again mid-sweep → ignored; clear_busy still drops exactly 256 cycles after the first pulse.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one dpram port between two req/ack requesters
// with round-robin arbitration, a tagged read-return pipeline and a fill
// engine that sweeps every word with a constant value.
module dpram_port_arbiter #(
  parameter int DATAWIDTH      = 8,
  parameter int ADDRWIDTH      = 8,
  parameter int NUMWORDS       = 1 << ADDRWIDTH,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_start,
  input  logic [DATAWIDTH-1:0] clear_value,
  output logic                 clear_busy,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [DATAWIDTH-1:0] din0,
  output logic                 ack0,
  output logic                 rvalid0,
  output logic [DATAWIDTH-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] din1,
  output logic                 ack1,
  output logic                 rvalid1,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_data,
  output logic                 ram_wren,
  input  logic [DATAWIDTH-1:0] ram_q
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int CW = ADDRWIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUMWORDS - 1);

  logic [0:0]           state;
  logic [CW-1:0]        cnt;
  logic [DATAWIDTH-1:0] fill_value;
  logic                 last_grant;
  logic                 boot;
  logic                 rd_v1, rd_id1;
  logic                 rd_v2, rd_id2;

  logic start_clear;
  logic arb_en;
  logic gnt0, gnt1;

  // Decide between starting a sweep and arbitrating; the last sweep cycle
  // also arbitrates so a waiting requester is acked on the first idle cycle.
  always_comb begin
    start_clear = 1'b0;
    arb_en      = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    if (state == ST_IDLE) begin
      start_clear = clear_start | (CLEAR_ON_RESET & boot);
      arb_en      = ~start_clear;
    end else begin
      arb_en = (cnt == CNT_LAST);
    end
    gnt0 = arb_en & req0 & (~req1 | last_grant);
    gnt1 = arb_en & req1 & (~req0 | ~last_grant);
  end

  // Fill sequencing, grant issue and registered RAM-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      fill_value <= '0;
      last_grant <= 1'b1;
      boot       <= 1'b1;
      clear_busy <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      rd_v1      <= 1'b0;
      rd_id1     <= 1'b0;
    end else begin
      boot     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      ram_wren <= 1'b0;
      rd_v1    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            fill_value <= clear_start ? clear_value : '0;
            clear_busy <= 1'b1;
            ram_addr   <= '0;
            ram_data   <= clear_start ? clear_value : '0;
            ram_wren   <= 1'b1;
          end
        end
        default: begin
          // cnt names the word currently presented on the RAM pins.
          if (cnt == CNT_LAST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            ram_addr <= ADDRWIDTH'(cnt + 1'b1);
            ram_data <= fill_value;
            ram_wren <= 1'b1;
          end
        end
      endcase

      if (gnt0) begin
        ram_addr   <= addr0;
        ram_data   <= din0;
        ram_wren   <= we0;
        ack0       <= 1'b1;
        last_grant <= 1'b0;
        rd_v1      <= ~we0;
        rd_id1     <= 1'b0;
      end else if (gnt1) begin
        ram_addr   <= addr1;
        ram_data   <= din1;
        ram_wren   <= we1;
        ack1       <= 1'b1;
        last_grant <= 1'b1;
        rd_v1      <= ~we1;
        rd_id1     <= 1'b1;
      end
    end
  end

  // Read return: the tag follows the RAM latency and steers ram_q to its owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_v2   <= 1'b0;
      rd_id2  <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rd_v2   <= rd_v1;
      rd_id2  <= rd_id1;
      rvalid0 <= rd_v2 & ~rd_id2;
      rvalid1 <= rd_v2 & rd_id2;
      if (rd_v2 & ~rd_id2) rdata0 <= ram_q;
      if (rd_v2 & rd_id2)  rdata1 <= ram_q;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of memory and arbitration.
module tb_dpram_port_arbiter;

  logic       clock;
  logic       reset;
  logic       clear_start;
  logic [7:0] clear_value;
  logic       clear_busy;
  logic       req0, we0, ack0, rvalid0;
  logic [7:0] addr0, din0, rdata0;
  logic       req1, we1, ack1, rvalid1;
  logic [7:0] addr1, din1, rdata1;
  logic [7:0] ram_addr, ram_data, ram_q;
  logic       ram_wren;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] model_mem [256];

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } exp_t;

  dpram_port_arbiter #(
    .DATAWIDTH(8),
    .ADDRWIDTH(8),
    .NUMWORDS(256),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Single-port view of the dpram: registered address, new-data reads.
  logic [7:0] mem [256];
  logic [7:0] addr_q;
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic fill_model(input logic [7:0] v);
    for (int unsigned i = 0; i < 256; i++) model_mem[i] = v;
  endtask

  task automatic test_reset();
    int n;
    int idx;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_data, ram_wren, clear_busy} !== '0)
      begin errors++; $display("FAIL reset_outputs: got ack=%b%b rv=%b%b rd=%h/%h addr=%h data=%h wren=%b busy=%b, expected all 0",
        ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_data, ram_wren, clear_busy); end
    reset = 1'b0;
    n = 0;
    while (!clear_busy && n < 8) begin tick(); n++; end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL auto_fill_start: busy after %0d cycles, expected 1", n); end
    idx = 0;
    while (clear_busy && idx < 300) begin
      checks++;
      if (ram_wren !== 1'b1 || ram_addr !== idx[7:0] || ram_data !== 8'h00)
        begin errors++; $display("FAIL auto_fill_word: got wren=%b addr=%h data=%h, expected 1/%h/00", ram_wren, ram_addr, ram_data, idx[7:0]); end
      idx++;
      tick();
    end
    checks++;
    if (idx !== 256) begin errors++; $display("FAIL auto_fill_len: busy %0d cycles, expected 256", idx); end
    fill_model(8'h00);
    // both read 0x7F; requester 0 wins the first contest
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h7F;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h7F;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL first_contest: got ack=%b%b, expected ack0 only", ack0, ack1); end
    req0 = 1'b0;
    tick();
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin errors++; $display("FAIL second_grant: got ack=%b%b, expected ack1 only", ack0, ack1); end
    req1 = 1'b0;
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== model_mem[8'h7F])
      begin errors++; $display("FAIL read7f_r0: got rv=%b%b rdata0=%h, expected rv0 with %h", rvalid0, rvalid1, rdata0, model_mem[8'h7F]); end
    tick();
    checks++;
    if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== model_mem[8'h7F])
      begin errors++; $display("FAIL read7f_r1: got rv=%b%b rdata1=%h, expected rv1 with %h", rvalid0, rvalid1, rdata1, model_mem[8'h7F]); end
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; din0 = 8'h5A;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 8'h10 || ram_data !== 8'h5A)
      begin errors++; $display("FAIL wr_issue: got ack0=%b wren=%b addr=%h data=%h, expected 1/1/10/5A", ack0, ram_wren, ram_addr, ram_data); end
    model_mem[8'h10] = 8'h5A;
    we0 = 1'b0;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== 8'h10)
      begin errors++; $display("FAIL rd_issue: got ack0=%b wren=%b addr=%h, expected 1/0/10", ack0, ram_wren, ram_addr); end
    req0 = 1'b0;
    tick();
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || ack0 !== 1'b0)
      begin errors++; $display("FAIL rd_latency1: got rv=%b%b ack0=%b, expected 0", rvalid0, rvalid1, ack0); end
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A || rvalid1 !== 1'b0)
      begin errors++; $display("FAIL rd_return: got rv=%b%b rdata0=%h, expected rv0 with 5A", rvalid0, rvalid1, rdata0); end
    tick();
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'h5A)
      begin errors++; $display("FAIL rd_pulse: got rvalid0=%b rdata0=%h, expected 0 and held 5A", rvalid0, rdata0); end
  endtask

  task automatic test_alternate();
    int id;
    logic [7:0] exp_d;
    // preload through requester 1 so requester 0 wins the next contest
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h01; din1 = 8'hA1;
    tick();
    checks++;
    if (ack1 !== 1'b1) begin errors++; $display("FAIL preload_a1: got ack1=%b, expected 1", ack1); end
    model_mem[8'h01] = 8'hA1;
    addr1 = 8'h02; din1 = 8'hA2;
    tick();
    checks++;
    if (ack1 !== 1'b1) begin errors++; $display("FAIL preload_a2: got ack1=%b, expected 1", ack1); end
    model_mem[8'h02] = 8'hA2;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    we1 = 1'b0; addr1 = 8'h02;
    for (int k = 0; k < 6; k++) begin
      tick();
      id = k % 2;
      checks++;
      if (k < 4) begin
        if (ack0 !== (id == 0) || ack1 !== (id == 1))
          begin errors++; $display("FAIL alt_ack%0d: got ack=%b%b, expected requester %0d", k, ack0, ack1, id); end
      end else begin
        if (ack0 !== 1'b0 || ack1 !== 1'b0)
          begin errors++; $display("FAIL alt_noack%0d: got ack=%b%b, expected 00", k, ack0, ack1); end
      end
      if (k >= 2) begin
        exp_d = (id == 0) ? model_mem[8'h01] : model_mem[8'h02];
        checks++;
        if (rvalid0 !== (id == 0) || rvalid1 !== (id == 1) || (id == 0 ? rdata0 : rdata1) !== exp_d)
          begin errors++; $display("FAIL alt_rdata%0d: got rv=%b%b rd=%h/%h, expected requester %0d data %h", k, rvalid0, rvalid1, rdata0, rdata1, id, exp_d); end
      end
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_clear_pending();
    int n;
    logic [7:0] a;
    a = 8'($urandom);
    clear_value = 8'hFF; clear_start = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = a;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clear_busy && n < 300) begin
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0)
        begin errors++; $display("FAIL clr_noack: got ack=%b%b at sweep cycle %0d, expected 00", ack0, ack1, n); end
      n++;
      tick();
    end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL clr_len: busy %0d cycles, expected 256", n); end
    fill_model(8'hFF);
    checks++;
    if (ack1 !== 1'b1 || ram_addr !== a || ram_wren !== 1'b0)
      begin errors++; $display("FAIL clr_first_idle_ack: got ack1=%b addr=%h wren=%b, expected 1/%h/0", ack1, ram_addr, ram_wren, a); end
    req1 = 1'b0;
    tick();
    tick();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== model_mem[a])
      begin errors++; $display("FAIL clr_readback: got rvalid1=%b rdata1=%h, expected 1/%h", rvalid1, rdata1, model_mem[a]); end
  endtask

  task automatic test_clear_restart();
    int n;
    clear_value = 8'h3C; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clear_busy && n < 300) begin
      checks++;
      if (ram_wren !== 1'b1 || ram_data !== 8'h3C || ram_addr !== n[7:0])
        begin errors++; $display("FAIL restart_word: got wren=%b addr=%h data=%h, expected 1/%h/3C", ram_wren, ram_addr, ram_data, n[7:0]); end
      if (n == 100) begin clear_start = 1'b1; clear_value = 8'h99; end
      else clear_start = 1'b0;
      n++;
      tick();
    end
    clear_start = 1'b0;
    checks++;
    if (n !== 256) begin errors++; $display("FAIL restart_len: busy %0d cycles, expected 256", n); end
    fill_model(8'h3C);
  endtask

  task automatic test_random();
    bit         p_v [2];
    bit         p_we[2];
    logic [7:0] p_a [2];
    logic [7:0] p_d [2];
    int         mlast;
    int         win;
    exp_t       rq[$];
    exp_t       e;
    bit         ev0, ev1;
    logic [7:0] ed;
    mlast = 1;  // last grant before this run went to requester 1
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      win = -1;
      if (p_v[0] && p_v[1]) win = (mlast == 1) ? 0 : 1;
      else if (p_v[0]) win = 0;
      else if (p_v[1]) win = 1;
      tick();
      checks++;
      if (ack0 !== (win == 0) || ack1 !== (win == 1))
        begin errors++; $display("FAIL rnd_ack: cycle %0d got ack=%b%b, expected winner %0d", cyc, ack0, ack1, win); end
      if (win >= 0) begin
        checks++;
        if (ram_wren !== p_we[win] || ram_addr !== p_a[win] || (p_we[win] && ram_data !== p_d[win]))
          begin errors++; $display("FAIL rnd_issue: cycle %0d got wren=%b addr=%h data=%h, expected %b/%h/%h", cyc, ram_wren, ram_addr, ram_data, p_we[win], p_a[win], p_d[win]); end
        if (p_we[win]) model_mem[p_a[win]] = p_d[win];
        else begin
          e.due = cyc + 2; e.id = (win == 1); e.data = model_mem[p_a[win]];
          rq.push_back(e);
        end
        mlast = win;
      end
      ev0 = 1'b0; ev1 = 1'b0; ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        ev0 = !e.id; ev1 = e.id; ed = e.data;
      end
      checks++;
      if (rvalid0 !== ev0 || rvalid1 !== ev1 || (ev0 && rdata0 !== ed) || (ev1 && rdata1 !== ed))
        begin errors++; $display("FAIL rnd_rvalid: cycle %0d got rv=%b%b rd=%h/%h, expected rv=%b%b data %h", cyc, rvalid0, rvalid1, rdata0, rdata1, ev0, ev1, ed); end
      for (int r = 0; r < 2; r++) begin
        if (n >= 395) p_v[r] = 1'b0;
        else if (!p_v[r] || r == win) begin
          p_v[r]  = ($urandom_range(0, 3) != 0);
          p_we[r] = 1'($urandom_range(0, 1));
          p_a[r]  = 8'($urandom_range(0, 15));
          p_d[r]  = 8'($urandom);
        end
      end
      req0 = p_v[0]; we0 = p_we[0]; addr0 = p_a[0]; din0 = p_d[0];
      req1 = p_v[1]; we1 = p_we[1]; addr1 = p_a[1]; din1 = p_d[1];
    end
    checks++;
    if (rq.size() !== 0) begin errors++; $display("FAIL rnd_drain: %0d reads never returned, expected 0", rq.size()); end
  endtask

  task automatic test_reset_inflight();
    bit seen;
    int n;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    checks++;
    if (ack0 !== 1'b1) begin errors++; $display("FAIL inflight_ack: got ack0=%b, expected 1", ack0); end
    req0 = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_data, ram_wren, clear_busy} !== '0)
      begin errors++; $display("FAIL inflight_reset_outputs: got rv=%b%b rd=%h/%h addr=%h wren=%b busy=%b, expected all 0",
        rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_wren, clear_busy); end
    reset = 1'b0;
    seen = 1'b0;
    n = 0;
    while (n < 400 && !(seen && !clear_busy)) begin
      tick();
      if (clear_busy) seen = 1'b1;
      checks++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
        begin errors++; $display("FAIL inflight_discard: got rv=%b%b, expected 00", rvalid0, rvalid1); end
      n++;
    end
    checks++;
    if (!seen || clear_busy) begin errors++; $display("FAIL inflight_refill: sweep seen=%b busy=%b, expected completed sweep", seen, clear_busy); end
    fill_model(8'h00);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL post_reset_contest: got ack=%b%b, expected ack0 only", ack0, ack1); end
    req0 = 1'b0;
    tick();
    checks++;
    if (ack1 !== 1'b1) begin errors++; $display("FAIL post_reset_second: got ack1=%b, expected 1", ack1); end
    req1 = 1'b0;
    tick();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== model_mem[8'h10])
      begin errors++; $display("FAIL post_reset_read: got rvalid0=%b rdata0=%h, expected 1/%h", rvalid0, rdata0, model_mem[8'h10]); end
    tick();
  endtask

  initial begin
    reset = 1'b1; clear_start = 1'b0; clear_value = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_clear_pending();
    test_clear_restart();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
